pipeline_hazard_ctrl: RTL and testbench

- Sequencing controller for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Starts execution on command and detects load-use hazards, inserting one bubble.
- Drives branch flush when the branch resolves in EX/MEM, generates EX-stage forwarding selects, drains the pipeline on a HALT opcode, and keeps performance counters.
- Sits beside the pipeline registers; the datapath consumes its enables, bubbles and flushes.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 25 ++
 rtl/pipeline_hazard_ctrl_forwarding_unit.sv | 27 ++
 rtl/pipeline_hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared opcode, FSM state and forwarding-select definitions for the 5-stage pipeline controller.
package pipeline_hazard_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StHalt} ctrlStateE;

  // Opcodes whose rt field is a source operand rather than a destination.
  function automatic logic usesRt(logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_forwarding_unit.sv
// EX-stage operand forwarding selects; EX/MEM takes priority over MEM/WB.
module forwarding_unit
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic       exmemRegWrite,
  input  logic [4:0] exmemRd,
  input  logic       memwbRegWrite,
  input  logic [4:0] memwbRd,
  input  logic [4:0] idexRs,
  input  logic [4:0] idexRt,
  output logic [1:0] fwdA,
  output logic [1:0] fwdB
);

  function automatic logic [1:0] selFor(logic exW, logic [4:0] exRd, logic wbW,
                                        logic [4:0] wbRd, logic [4:0] src);
    if (exW && (exRd != 5'd0) && (exRd == src)) return FWD_EXMEM;
    if (wbW && (wbRd != 5'd0) && (wbRd == src)) return FWD_MEMWB;
    return FWD_REG;
  endfunction

  always_comb begin
    fwdA = selFor(exmemRegWrite, exmemRd, memwbRegWrite, memwbRd, idexRs);
    fwdB = selFor(exmemRegWrite, exmemRd, memwbRegWrite, memwbRd, idexRt);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: start/halt FSM, load-use stall, branch flush,
// forwarding selects and performance counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter logic [5:0]  HALT_OPCODE  = OP_HALT,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       ifid_opcode,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic [4:0]       idex_rs,
  input  logic [4:0]       idex_rt,
  input  logic             idex_mem_read,
  input  logic             exmem_reg_write,
  input  logic [4:0]       exmem_rd,
  input  logic             exmem_branch_taken,
  input  logic             memwb_reg_write,
  input  logic [4:0]       memwb_rd,
  output logic             pc_write,
  output logic             pc_src,
  output logic             if_id_write,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             id_ex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic [31:0]      cycle_count,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned DrainW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

  ctrlStateE         stateQ;
  logic [DrainW-1:0] drainCntQ;
  logic [31:0]       cycleCntQ;
  logic [CNT_W-1:0]  stallCntQ;
  logic [CNT_W-1:0]  flushCntQ;

  logic       haltSeen;
  logic       loadUse;
  logic       stallEvent;
  logic       flushEvent;
  logic       fwdEn;
  logic [1:0] fwdA;
  logic [1:0] fwdB;

  forwarding_unit uFwd (
    .exmemRegWrite(exmem_reg_write),
    .exmemRd      (exmem_rd),
    .memwbRegWrite(memwb_reg_write),
    .memwbRd      (memwb_rd),
    .idexRs       (idex_rs),
    .idexRt       (idex_rt),
    .fwdA         (fwdA),
    .fwdB         (fwdB)
  );

  always_comb begin
    haltSeen = (ifid_opcode == HALT_OPCODE);
    loadUse  = idex_mem_read && (idex_rt != 5'd0) &&
               ((idex_rt == ifid_rs) || (usesRt(ifid_opcode) && (idex_rt == ifid_rt)));

    // Frozen front end is the default; RUN and branch recovery open it up.
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    id_ex_bubble = 1'b1;
    pc_src       = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    stallEvent   = 1'b0;
    flushEvent   = 1'b0;
    fwdEn        = 1'b0;

    unique case (stateQ)
      StRun, StDrain: begin
        fwdEn = 1'b1;
        if (exmem_branch_taken) begin
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          id_ex_bubble = 1'b0;
          pc_src       = 1'b1;
          flush_if_id  = 1'b1;
          flush_id_ex  = 1'b1;
          flush_ex_mem = 1'b1;
          flushEvent   = 1'b1;
        end else if (stateQ == StRun && !haltSeen) begin
          if (loadUse) begin
            stallEvent = 1'b1;
          end else begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_bubble = 1'b0;
          end
        end
      end
      default: ;
    endcase

    fwd_a = fwdEn ? fwdA : FWD_REG;
    fwd_b = fwdEn ? fwdB : FWD_REG;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ    <= StIdle;
      drainCntQ <= '0;
      cycleCntQ <= '0;
      stallCntQ <= '0;
      flushCntQ <= '0;
    end else begin
      unique case (stateQ)
        StIdle: if (start) stateQ <= StRun;
        StRun: begin
          if (!exmem_branch_taken && haltSeen) begin
            stateQ    <= StDrain;
            drainCntQ <= DrainW'(DRAIN_CYCLES - 1);
          end
        end
        StDrain: begin
          // A branch resolving during drain means the HALT was fetched down a wrong path.
          if (exmem_branch_taken) begin
            stateQ    <= StRun;
            drainCntQ <= '0;
          end else if (drainCntQ == '0) begin
            stateQ <= StHalt;
          end else begin
            drainCntQ <= drainCntQ - DrainW'(1);
          end
        end
        default: stateQ <= StHalt;
      endcase

      if (stateQ == StRun || stateQ == StDrain) cycleCntQ <= cycleCntQ + 32'd1;
      if (stallEvent && stallCntQ != '1) stallCntQ <= stallCntQ + CNT_W'(1);
      if (flushEvent && flushCntQ != '1) flushCntQ <= flushCntQ + CNT_W'(1);
    end
  end

  assign halted      = (stateQ == StHalt);
  assign cycle_count = cycleCntQ;
  assign stall_count = stallCntQ;
  assign flush_count = flushCntQ;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  ifid_opcode;
  logic [4:0]  ifid_rs, ifid_rt, idex_rs, idex_rt;
  logic        idex_mem_read;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic        exmem_branch_taken;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic        pc_write, pc_src, if_id_write;
  logic        flush_if_id, flush_id_ex, flush_ex_mem, id_ex_bubble;
  logic [1:0]  fwd_a, fwd_b;
  logic        halted;
  logic [31:0] cycle_count;
  logic [15:0] stall_count, flush_count;

  int nVec = 0;
  int nMiss = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .ifid_opcode       (ifid_opcode),
    .ifid_rs           (ifid_rs),
    .ifid_rt           (ifid_rt),
    .idex_rs           (idex_rs),
    .idex_rt           (idex_rt),
    .idex_mem_read     (idex_mem_read),
    .exmem_reg_write   (exmem_reg_write),
    .exmem_rd          (exmem_rd),
    .exmem_branch_taken(exmem_branch_taken),
    .memwb_reg_write   (memwb_reg_write),
    .memwb_rd          (memwb_rd),
    .pc_write          (pc_write),
    .pc_src            (pc_src),
    .if_id_write       (if_id_write),
    .flush_if_id       (flush_if_id),
    .flush_id_ex       (flush_id_ex),
    .flush_ex_mem      (flush_ex_mem),
    .id_ex_bubble      (id_ex_bubble),
    .fwd_a             (fwd_a),
    .fwd_b             (fwd_b),
    .halted            (halted),
    .cycle_count       (cycle_count),
    .stall_count       (stall_count),
    .flush_count       (flush_count)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nMiss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    start = 0; ifid_opcode = 6'h00; ifid_rs = 0; ifid_rt = 0; idex_rs = 0; idex_rt = 0;
    idex_mem_read = 0; exmem_reg_write = 0; exmem_rd = 0; exmem_branch_taken = 0;
    memwb_reg_write = 0; memwb_rd = 0;
  endtask

  task automatic resetAndStart();
    clearInputs();
    rst_n = 0;
    #2;
    rst_n = 1;
    step();
    start = 1;
    step();
    start = 0;
  endtask

  task automatic setLoadUse();
    idex_mem_read = 1; idex_rt = 5'd2; ifid_opcode = 6'h00; ifid_rs = 5'd2; ifid_rt = 5'd4;
  endtask

  initial begin
    clearInputs();
    rst_n = 0;
    // Forwarding match present in IDLE must not produce a select.
    exmem_reg_write = 1; exmem_rd = 5'd5; idex_rs = 5'd5;
    #3;
    checkVal("idle_pc_write", pc_write, 0);
    checkVal("idle_bubble", id_ex_bubble, 1);
    checkVal("idle_fwd_a", fwd_a, 0);
    checkVal("idle_halted", halted, 0);
    checkVal("rst_cycle", cycle_count, 0);
    rst_n = 1;
    clearInputs();
    step();
    checkVal("idle_wait_pc_write", pc_write, 0);
    start = 1;
    step();
    start = 0;
    #1;
    checkVal("run_pc_write", pc_write, 1);
    checkVal("run_if_id_write", if_id_write, 1);
    checkVal("run_cycle0", cycle_count, 0);
    step();
    checkVal("run_cycle1", cycle_count, 1);

    // Load-use on rs
    setLoadUse();
    #1;
    checkVal("lu_pc_write", pc_write, 0);
    checkVal("lu_bubble", id_ex_bubble, 1);
    checkVal("lu_if_id_write", if_id_write, 0);
    step();
    idex_mem_read = 0;
    #1;
    checkVal("lu_release", pc_write, 1);
    checkVal("lu_stall_count", stall_count, 1);
    // Load into r0 never stalls
    idex_mem_read = 1; idex_rt = 5'd0; ifid_rs = 5'd0;
    #1;
    checkVal("lu_r0_pc_write", pc_write, 1);
    // ADDI's rt is a destination, so an rt-only match is not a hazard
    idex_rt = 5'd2; ifid_opcode = 6'h08; ifid_rs = 5'd3; ifid_rt = 5'd2;
    #1;
    checkVal("lu_addi_pc_write", pc_write, 1);
    // SW reads rt, so the same match stalls
    ifid_opcode = 6'h2B;
    #1;
    checkVal("lu_sw_pc_write", pc_write, 0);
    step();
    clearInputs();
    #1;
    checkVal("lu_sw_stall_count", stall_count, 2);

    // Branch beats load-use
    resetAndStart();
    setLoadUse();
    exmem_branch_taken = 1;
    #1;
    checkVal("br_pc_src", pc_src, 1);
    checkVal("br_flush_if_id", flush_if_id, 1);
    checkVal("br_flush_id_ex", flush_id_ex, 1);
    checkVal("br_flush_ex_mem", flush_ex_mem, 1);
    checkVal("br_bubble", id_ex_bubble, 0);
    checkVal("br_pc_write", pc_write, 1);
    step();
    clearInputs();
    #1;
    checkVal("br_flush_count", flush_count, 1);
    checkVal("br_stall_count", stall_count, 0);
    checkVal("br_pc_src_off", pc_src, 0);

    // Forwarding
    exmem_reg_write = 1; memwb_reg_write = 1; exmem_rd = 5'd5; memwb_rd = 5'd5; idex_rs = 5'd5;
    #1;
    checkVal("fwd_a_exmem", fwd_a, 2'b10);
    exmem_reg_write = 0;
    #1;
    checkVal("fwd_a_memwb", fwd_a, 2'b01);
    exmem_rd = 0; memwb_rd = 0;
    #1;
    checkVal("fwd_a_r0", fwd_a, 2'b00);
    exmem_reg_write = 1; exmem_rd = 5'd5; memwb_rd = 5'd7; idex_rt = 5'd7;
    #1;
    checkVal("fwd_a_mixed", fwd_a, 2'b10);
    checkVal("fwd_b_mixed", fwd_b, 2'b01);
    clearInputs();

    // HALT drain
    ifid_opcode = 6'h3F;
    #1;
    checkVal("halt_pc_write", pc_write, 0);
    checkVal("halt_bubble", id_ex_bubble, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      checkVal($sformatf("drain%0d_halted", i), halted, 0);
      checkVal($sformatf("drain%0d_pc_write", i), pc_write, 0);
    end
    step();
    checkVal("halt_halted", halted, 1);
    checkVal("halt_state_pc_write", pc_write, 0);
    start = 1;
    step();
    start = 0;
    step();
    checkVal("halt_ignores_start", halted, 1);

    // Speculative HALT cancelled by a branch in drain
    resetAndStart();
    ifid_opcode = 6'h3F;
    step();
    exmem_branch_taken = 1;
    #1;
    checkVal("spec_pc_src", pc_src, 1);
    checkVal("spec_flush_ex_mem", flush_ex_mem, 1);
    checkVal("spec_pc_write", pc_write, 1);
    step();
    clearInputs();
    #1;
    checkVal("spec_run_pc_write", pc_write, 1);
    checkVal("spec_flush_count", flush_count, 1);
    for (int i = 0; i < 4; i++) step();
    checkVal("spec_never_halted", halted, 0);

    // Stall counter saturation
    force dut.stallCntQ = 16'hFFFF;
    #1;
    release dut.stallCntQ;
    setLoadUse();
    #1;
    checkVal("sat_pc_write", pc_write, 0);
    step();
    clearInputs();
    #1;
    checkVal("sat_stall_count", stall_count, 16'hFFFF);

    // Async reset mid-drain
    ifid_opcode = 6'h3F;
    step();
    step();
    rst_n = 0;
    #1;
    checkVal("mid_rst_halted", halted, 0);
    checkVal("mid_rst_pc_write", pc_write, 0);
    checkVal("mid_rst_bubble", id_ex_bubble, 1);
    checkVal("mid_rst_stall", stall_count, 0);
    checkVal("mid_rst_flush", flush_count, 0);
    checkVal("mid_rst_cycle", cycle_count, 0);
    clearInputs();
    rst_n = 1;
    step();
    checkVal("post_rst_idle", pc_write, 0);
    checkVal("post_rst_cycle", cycle_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
